// File: rtl/mem_responder.sv
// Word-organised memory on the responder side of the CPU memory port.
// Accepts a request, waits WAIT_STATES cycles, then acks with read data or a committed write.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   err_q;

    logic [31:0]            mem [DEPTH_WORDS];

    logic [ADDR_BITS-1:0]   index_d;
    logic                   align_err_d;
    logic                   range_err_d;
    logic                   acc_err_d;
    logic                   mem_wr_d;

    assign index_d     = addr_q[ADDR_BITS+1:2];
    assign align_err_d = (addr_q[1:0] != 2'b00);
    // Any byte-address bit above the word index means the access is past the array.
    assign range_err_d = |(addr_q >> (ADDR_BITS + 2));
    assign acc_err_d   = align_err_d | range_err_d;
    // Reset in the response cycle still wins, so an aborted write never lands.
    assign mem_wr_d    = (state_q == S_RESP) && we_q && !acc_err_d && !reset;

    always_ff @(posedge clk) begin
        if (mem_wr_d) begin
            mem[index_d] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            cnt_q   <= 4'(WAIT_STATES - 1);
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    // busy covers the cycles before the ack; it falls as ack rises.
                    state_q <= S_IDLE;
                    ack_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= acc_err_d;
                    if (acc_err_d || we_q) begin
                        rdata_q <= 32'd0;
                    end else begin
                        rdata_q <= mem[index_d];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES of 0, 1 and 3,
// driven on the falling edge and sampled on the falling edge.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, ack0, busy0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ack1, busy1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        req3, we3, ack3, busy3, err3;
    logic [31:0] addr3, wdata3, rdata3;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
    );
    mem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
    );
    mem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .rdata(rdata3), .ack(ack3), .busy(busy3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instance selector equals that instance's WAIT_STATES.
    task automatic set_in(input int inst, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        case (inst)
            0: begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
            1: begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
            default: begin req3 = r; we3 = w; addr3 = a; wdata3 = d; end
        endcase
    endtask

    function automatic logic o_ack(input int inst);
        return (inst == 0) ? ack0 : (inst == 1) ? ack1 : ack3;
    endfunction
    function automatic logic o_busy(input int inst);
        return (inst == 0) ? busy0 : (inst == 1) ? busy1 : busy3;
    endfunction
    function automatic logic o_err(input int inst);
        return (inst == 0) ? err0 : (inst == 1) ? err1 : err3;
    endfunction
    function automatic logic [31:0] o_rdata(input int inst);
        return (inst == 0) ? rdata0 : (inst == 1) ? rdata1 : rdata3;
    endfunction

    // One access: latency WS+1 edges after acceptance, busy for WS+1 cycles, then no stray ack.
    task automatic acc(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input bit poke,
                       input string tag);
        int lat;
        int bcnt;
        int extra;
        @(negedge clk);
        set_in(inst, 1'b1, w, a, d);
        @(negedge clk);
        set_in(inst, 1'b0, ~w, $urandom, $urandom);
        lat  = 0;
        bcnt = 0;
        while (o_ack(inst) !== 1'b1 && lat < 20) begin
            if (o_busy(inst) === 1'b1) bcnt++;
            if (poke && lat == 0) set_in(inst, 1'b1, 1'b0, 32'h4, $urandom);
            else                  set_in(inst, 1'b0, ~w, $urandom, $urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(inst + 1));
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(inst + 1));
        chk({tag, ".busy_at_ack"}, 32'(o_busy(inst)), 32'd0);
        chk({tag, ".err"}, 32'(o_err(inst)), 32'(exp_err));
        chk({tag, ".rdata"}, o_rdata(inst), exp_rd);
        set_in(inst, 1'b0, 1'b0, 32'd0, 32'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_ack(inst) === 1'b1) extra++;
        end
        chk({tag, ".no_extra_ack"}, 32'(extra), 32'd0);
        $display("txn %s inst=%0d we=%0b addr=%h lat=%0d err=%0b rdata=%h",
                 tag, inst, w, a, lat, o_err(inst), o_rdata(inst));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int aborted_acks;
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_in(3, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int inst;
            inst = (i == 2) ? 3 : i;
            chk($sformatf("reset%0d.ack", inst), 32'(o_ack(inst)), 32'd0);
            chk($sformatf("reset%0d.busy", inst), 32'(o_busy(inst)), 32'd0);
            chk($sformatf("reset%0d.err", inst), 32'(o_err(inst)), 32'd0);
            chk($sformatf("reset%0d.rdata", inst), o_rdata(inst), 32'd0);
        end
        $display("txn reset: outputs checked on all instances");
        rst = 1'b0;

        // Write then read back, one wait state.
        acc(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, "wr10");
        acc(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd10");
        // Misaligned write must leave the word untouched.
        acc(1, 1'b1, 32'h12, 32'h1234, 32'd0, 1'b1, 1'b0, "wr12_misal");
        acc(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd10_after_misal");
        // One word past the array.
        acc(1, 1'b0, 32'h400, 32'h0, 32'd0, 1'b1, 1'b0, "rd400_range");
        // Request pulsed during WAIT is ignored.
        acc(1, 1'b1, 32'h0, 32'h55AA33CC, 32'd0, 1'b0, 1'b0, "wr0");
        acc(1, 1'b1, 32'h4, 32'h99887766, 32'd0, 1'b0, 1'b0, "wr4");
        acc(1, 1'b0, 32'h0, 32'h0, 32'h55AA33CC, 1'b0, 1'b1, "rd0_poke");

        // Reset mid-access, three wait states.
        acc(3, 1'b1, 32'h20, 32'h11112222, 32'd0, 1'b0, 1'b0, "ws3_wr20");
        @(negedge clk);
        set_in(3, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        set_in(3, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.ack", 32'(ack3), 32'd0);
        chk("midrst.busy", 32'(busy3), 32'd0);
        chk("midrst.err", 32'(err3), 32'd0);
        chk("midrst.rdata", rdata3, 32'd0);
        chk("midrst.ws1_rdata_cleared", rdata1, 32'd0);
        rst = 1'b0;
        aborted_acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack3 === 1'b1) aborted_acks++;
        end
        chk("midrst.no_ack", 32'(aborted_acks), 32'd0);
        $display("txn midrst: write 0x20 aborted, acks seen=%0d", aborted_acks);
        acc(3, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, 1'b0, "ws3_rd20");

        // Zero wait states with req held high.
        acc(0, 1'b1, 32'h0, 32'hA0A0A0A0, 32'd0, 1'b0, 1'b0, "ws0_wr0");
        acc(0, 1'b1, 32'h4, 32'h0B0B0B0B, 32'd0, 1'b0, 1'b0, "ws0_wr4");
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_rd;
            exp_rd = (k % 2 == 0) ? 32'hA0A0A0A0 : 32'h0B0B0B0B;
            @(negedge clk);
            chk($sformatf("stream%0d.gap_ack", k), 32'(ack0), 32'd0);
            chk($sformatf("stream%0d.busy", k), 32'(busy0), 32'd1);
            @(negedge clk);
            chk($sformatf("stream%0d.ack", k), 32'(ack0), 32'd1);
            chk($sformatf("stream%0d.err", k), 32'(err0), 32'd0);
            chk($sformatf("stream%0d.rdata", k), rdata0, exp_rd);
            $display("txn stream%0d addr=%h ack=%0b rdata=%h", k, (k % 2 == 0) ? 32'h0 : 32'h4,
                     ack0, rdata0);
            set_in(0, 1'b1, 1'b0, (k % 2 == 0) ? 32'h4 : 32'h0, 32'h0);
        end
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
